// File: rtl/implication_queue.sv
// rtl/implication_queue.sv - implication FIFO with duplicate drop and conflict detection
// Buffers forced variable/value pairs from the unit-clause evaluators toward the trail logic.
module implication_queue #(
    parameter int NUM_VARIABLE   = 128,
    parameter int VARIABLE_INDEX = 6,
    parameter int DEPTH          = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic                      unit_clause,
    input  logic [VARIABLE_INDEX:0]   in_var,
    input  logic                      in_val,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [VARIABLE_INDEX:0]   out_var,
    output logic                      out_val,
    output logic                      conflict,
    output logic [VARIABLE_INDEX:0]   conflict_var,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int VAR_W = VARIABLE_INDEX + 1;
    localparam int ENT_W = VAR_W + 1;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_CONFLICT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]          count_q, count_d;
    logic [NUM_VARIABLE-1:0] pending_q, pending_d;
    logic [NUM_VARIABLE-1:0] pval_q, pval_d;
    logic [VAR_W-1:0]        conflict_var_q, conflict_var_d;
    logic [ENT_W-1:0]        mem_q [DEPTH];

    logic             run;
    logic             full;
    logic [ENT_W-1:0] head;
    logic [VAR_W-1:0] head_var;
    logic             accept;
    logic             hit;
    logic             push_en;
    logic             pop_en;
    logic             conflict_ev;

    assign run       = (state_q == ST_RUN);
    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign head      = mem_q[rd_ptr_q];
    assign head_var  = head[ENT_W-1:1];

    assign in_ready  = run & ~full;
    assign out_valid = run & (count_q != '0);
    // Storage is not reset, so the head is masked whenever nothing valid is held.
    assign out_var   = out_valid ? head_var : '0;
    assign out_val   = out_valid & head[0];

    assign conflict     = (state_q == ST_CONFLICT);
    assign conflict_var = conflict_var_q;
    assign count        = count_q;

    // Pending lookup uses pre-edge state, so a same-cycle pop of in_var still reads as pending.
    assign accept      = in_valid & unit_clause & in_ready;
    assign hit         = pending_q[in_var];
    assign push_en     = accept & ~hit & ~flush;
    assign conflict_ev = accept & hit & (pval_q[in_var] != in_val);
    assign pop_en      = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        pending_d      = pending_q;
        pval_d         = pval_q;
        conflict_var_d = conflict_var_q;

        if (pop_en) begin
            rd_ptr_d            = rd_ptr_q + PTR_W'(1);
            pending_d[head_var] = 1'b0;
        end

        if (push_en) begin
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            pending_d[in_var] = 1'b1;
            pval_d[in_var]    = in_val;
        end

        case ({push_en, pop_en})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        if (conflict_ev) begin
            state_d        = ST_CONFLICT;
            conflict_var_d = in_var;
        end

        if (flush) begin
            state_d        = ST_RUN;
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            count_d        = '0;
            pending_d      = '0;
            pval_d         = '0;
            conflict_var_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= ST_RUN;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            pending_q      <= '0;
            pval_q         <= '0;
            conflict_var_q <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            pending_q      <= pending_d;
            pval_q         <= pval_d;
            conflict_var_q <= conflict_var_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && push_en) begin
            mem_q[wr_ptr_q] <= {in_var, in_val};
        end
    end

endmodule

// File: tb/tb_implication_queue.sv
// tb/tb_implication_queue.sv - scoreboard bench for implication_queue
module tb_implication_queue;

    logic       clock;
    logic       reset_n;
    logic       flush;
    logic       in_valid;
    logic       unit_clause;
    logic [6:0] in_var;
    logic       in_val;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_var;
    logic       out_val;
    logic       conflict;
    logic [6:0] conflict_var;
    logic [4:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb[$];
    bit         m_pend [128];
    bit         m_pval [128];

    implication_queue #(
        .NUM_VARIABLE  (128),
        .VARIABLE_INDEX(6),
        .DEPTH         (16)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .unit_clause (unit_clause),
        .in_var      (in_var),
        .in_val      (in_val),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_var     (out_var),
        .out_val     (out_val),
        .conflict    (conflict),
        .conflict_var(conflict_var),
        .count       (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        sb.delete();
        for (int i = 0; i < 128; i++) begin
            m_pend[i] = 1'b0;
            m_pval[i] = 1'b0;
        end
    endtask

    task automatic push(input logic [6:0] v, input logic val);
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        check($sformatf("push_ready_v%0d", v), {31'd0, in_ready}, 32'd1);
        in_valid    = 1'b1;
        unit_clause = 1'b1;
        in_var      = v;
        in_val      = val;
        if (!m_pend[v]) begin
            sb.push_back({v, val});
            m_pend[v] = 1'b1;
            m_pval[v] = val;
        end
        step();
        in_valid    = 1'b0;
        unit_clause = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] exp;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            exp = 8'd0;
        end else begin
            exp = sb.pop_front();
        end
        check({tag, "_var"}, {25'd0, out_var}, {25'd0, exp[7:1]});
        check({tag, "_val"}, {31'd0, out_val}, {31'd0, exp[0]});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        m_pend[exp[7:1]] = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        unit_clause = 1'b0;
        in_var      = '0;
        in_val      = 1'b0;
        out_ready   = 1'b0;
        model_clear();

        // Reset
        step();
        step();
        reset_n = 1'b1;
        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_conflict", {31'd0, conflict}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_var", {25'd0, out_var}, 32'd0);

        // Ordered pair
        push(7'd5, 1'b1);
        check("ord_latency_valid", {31'd0, out_valid}, 32'd1);
        push(7'd9, 1'b0);
        check("ord_count2", {27'd0, count}, 32'd2);
        pop_check("ord_pop0");
        pop_check("ord_pop1");
        check("ord_count0", {27'd0, count}, 32'd0);

        // Duplicate dropped
        push(7'd7, 1'b1);
        push(7'd7, 1'b1);
        check("dup_count", {27'd0, count}, 32'd1);
        pop_check("dup_pop");
        check("dup_count0", {27'd0, count}, 32'd0);
        check("dup_empty", {31'd0, out_valid}, 32'd0);

        // Conflict then flush
        push(7'd7, 1'b1);
        push(7'd7, 1'b0);
        check("cf_conflict", {31'd0, conflict}, 32'd1);
        check("cf_var", {25'd0, conflict_var}, 32'd7);
        check("cf_in_ready", {31'd0, in_ready}, 32'd0);
        check("cf_out_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("cf_sticky", {31'd0, conflict}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        model_clear();
        check("fl_conflict", {31'd0, conflict}, 32'd0);
        check("fl_count", {27'd0, count}, 32'd0);
        check("fl_in_ready", {31'd0, in_ready}, 32'd1);

        // Fill, wrap, drain
        for (int i = 0; i < 16; i++) begin
            push(7'(i), 1'(i & 1));
        end
        check("full_count", {27'd0, count}, 32'd16);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        pop_check("full_pop");
        check("afterpop_in_ready", {31'd0, in_ready}, 32'd1);
        check("afterpop_count", {27'd0, count}, 32'd15);
        push(7'd20, 1'b1);
        check("wrap_count", {27'd0, count}, 32'd16);
        for (int i = 0; i < 16; i++) begin
            pop_check($sformatf("drain%0d", i));
        end
        check("drain_count", {27'd0, count}, 32'd0);

        // Non-unit result ignored
        in_valid    = 1'b1;
        unit_clause = 1'b0;
        in_var      = 7'd3;
        in_val      = 1'b1;
        step();
        in_valid    = 1'b0;
        check("nonunit_count", {27'd0, count}, 32'd0);
        check("nonunit_valid", {31'd0, out_valid}, 32'd0);

        // Flush beats concurrent push
        push(7'd11, 1'b1);
        in_valid    = 1'b1;
        unit_clause = 1'b1;
        in_var      = 7'd12;
        in_val      = 1'b0;
        flush       = 1'b1;
        step();
        flush       = 1'b0;
        in_valid    = 1'b0;
        unit_clause = 1'b0;
        model_clear();
        check("flpush_count", {27'd0, count}, 32'd0);
        check("flpush_valid", {31'd0, out_valid}, 32'd0);
        push(7'd12, 1'b0);
        pop_check("flpush_repush");

        // Same variable pushed while its entry pops: duplicate
        push(7'd40, 1'b1);
        check("sp_head_var", {25'd0, out_var}, 32'd40);
        in_valid    = 1'b1;
        unit_clause = 1'b1;
        in_var      = 7'd40;
        in_val      = 1'b1;
        out_ready   = 1'b1;
        void'(sb.pop_front());
        step();
        in_valid    = 1'b0;
        unit_clause = 1'b0;
        out_ready   = 1'b0;
        m_pend[40]  = 1'b0;
        check("sp_dup_count", {27'd0, count}, 32'd0);
        check("sp_dup_valid", {31'd0, out_valid}, 32'd0);

        // Same variable, opposite value while popping: conflict
        push(7'd41, 1'b1);
        in_valid    = 1'b1;
        unit_clause = 1'b1;
        in_var      = 7'd41;
        in_val      = 1'b0;
        out_ready   = 1'b1;
        step();
        in_valid    = 1'b0;
        unit_clause = 1'b0;
        out_ready   = 1'b0;
        check("sp_cf_conflict", {31'd0, conflict}, 32'd1);
        check("sp_cf_var", {25'd0, conflict_var}, 32'd41);
        check("sp_cf_count", {27'd0, count}, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        model_clear();
        check("end_conflict", {31'd0, conflict}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
